// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between fetch and data requesters.
// One transaction is outstanding at a time; a watchdog turns a missing response into an error reply.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [STRB_WIDTH-1:0] d_strb,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_strb,
  input  logic                  m_resp_valid,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state;
  logic                  last_d;
  logic                  own_d;
  logic [7:0]            cnt;
  logic                  grant_i;
  logic                  grant_d;
  logic                  done;
  logic [DATA_WIDTH-1:0] resp_data;

  // On conflict the requester not granted last time wins.
  always_comb begin
    grant_i = (state == IDLE) && i_req && (!d_req || last_d);
    grant_d = (state == IDLE) && d_req && (!i_req || !last_d);
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;

  // Response or watchdog expiry: reply goes out on the following cycle.
  always_comb begin
    done      = (state == WAIT) && (m_resp_valid || cnt == CNT_LAST);
    resp_data = (m_resp_valid && !m_we) ? m_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      last_d      <= 1'b1;
      own_d       <= 1'b0;
      cnt         <= '0;
      m_req_valid <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_strb      <= '0;
      i_rvalid    <= 1'b0;
      i_rdata     <= '0;
      i_err       <= 1'b0;
      d_rvalid    <= 1'b0;
      d_rdata     <= '0;
      d_err       <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            own_d       <= grant_d;
            last_d      <= grant_d;
            m_we        <= grant_d & d_we;
            m_addr      <= grant_d ? d_addr : i_addr;
            m_wdata     <= grant_d ? d_wdata : '0;
            m_strb      <= grant_d ? d_strb : '0;
            m_req_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_req_ready) begin
            cnt         <= '0;
            m_req_valid <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            if (own_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= resp_data;
              d_err    <= !m_resp_valid;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= resp_data;
              i_err    <= !m_resp_valid;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
